fpu8_arbiter: RTL

Round-robin arbiter that shares the single combinational `fpu8_wrap` datapath among `N` requesters. Each requester has a valid/ready request channel carrying `op`/`a`/`b` and a valid/ready response channel returning the 8-bit result. The block latches the winner's operands, holds them stable on the FPU inputs for `FPU_LAT` cycles, captures `out`, and returns it to the same requester. It sits between the requester logic and the `fpu8_wrap` instance, replacing direct pad drive of the FPU.

---
 rtl/fpu8_arb_pkg.sv | 38 +++
 rtl/rr_picker.sv | 48 ++++
 rtl/fpu8_arbiter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/fpu8_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fpu8_arb_pkg
// Purpose  : Shared types and constants for the fpu8 round-robin arbiter.
//            Holds the arbiter FSM state type, datapath widths, the latency
//            counter width and the pointer-advance helper.
// Revision : 1.0 - initial release
// ============================================================================
package fpu8_arb_pkg;

    // Datapath widths of the shared fpu8 unit
    localparam int OP_W   = 3;
    localparam int DATA_W = 8;

    // Latency counter width; holds FPU_LAT-1 for FPU_LAT up to 15
    localparam int LAT_W  = 4;

    // Requester index width; covers up to 8 requesters
    localparam int ID_W   = 3;

    // Arbiter FSM states, explicitly encoded
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    // Round-robin pointer advance: the requester after 'id', wrapping at n
    function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] id,
                                                 input int              n);
        if (int'(id) == n - 1) begin
            return '0;
        end
        return id + ID_W'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_picker.sv
`default_nettype none
// ============================================================================
// Module   : rr_picker
// Purpose  : Combinational round-robin picker. Scans 'req' starting at
//            index 'ptr' and wrapping modulo N; the first set bit wins.
// Ports    : req    [N-1:0]  request bits, one per requester
//            ptr    [ID_W-1] index the scan starts from (0..N-1)
//            gnt    [N-1:0]  one-hot winner (all zero when no request)
//            gnt_id [ID_W-1] index of the winner (0 when no request)
// Revision : 1.0 - initial release
// ============================================================================
module rr_picker
    import fpu8_arb_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] gnt_id
);

    always_comb begin : p_pick
        int   pos;
        logic found;
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        pos    = 0;
        // Scan offsets 0..N-1 from ptr; the wrapped position is compared
        // against every requester index so no out-of-range index is formed.
        for (int k = 0; k < N; k++) begin
            pos = int'(ptr) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            for (int j = 0; j < N; j++) begin
                if (!found && req[j] && (pos == j)) begin
                    gnt[j] = 1'b1;
                    gnt_id = ID_W'(j);
                    found  = 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fpu8_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fpu8_arbiter
// Purpose  : Shares one combinational fpu8 datapath among N requesters.
//            A round-robin winner's operands are latched, held on the FPU
//            inputs for FPU_LAT cycles, the FPU result is captured and
//            returned to the same requester over a valid/ready channel.
//            One transaction is outstanding at a time.
// Ports    : clk       clock, rising edge
//            reset     synchronous, active-low
//            req_vld   [N]     request valid per requester
//            req_op    [3N]    opcode, requester i at [3i+2:3i]
//            req_a/b   [8N]    operands, requester i at [8i+7:8i]
//            req_rdy   [N]     request accepted (at most one bit)
//            rsp_vld   [N]     response valid (only the granted requester)
//            rsp_data  [8]     shared result bus
//            rsp_rdy   [N]     response consumed, per requester
//            fpu_op/a/b        operands to the fpu8 wrapper
//            fpu_out   [8]     result from the fpu8 wrapper
//            busy              high while a transaction is in flight
//            grant_id  [3]     current or last granted requester
// Revision : 1.0 - initial release
// ============================================================================
module fpu8_arbiter
    import fpu8_arb_pkg::*;
#(
    parameter int N       = 3,
    parameter int FPU_LAT = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N-1:0]        req_vld,
    input  logic [OP_W*N-1:0]   req_op,
    input  logic [DATA_W*N-1:0] req_a,
    input  logic [DATA_W*N-1:0] req_b,
    output logic [N-1:0]        req_rdy,
    output logic [N-1:0]        rsp_vld,
    output logic [DATA_W-1:0]   rsp_data,
    input  logic [N-1:0]        rsp_rdy,
    output logic [OP_W-1:0]     fpu_op,
    output logic [DATA_W-1:0]   fpu_a,
    output logic [DATA_W-1:0]   fpu_b,
    input  logic [DATA_W-1:0]   fpu_out,
    output logic                busy,
    output logic [ID_W-1:0]     grant_id
);

    // Counter reload: EXEC ends in the cycle the counter reads zero, which
    // gives exactly FPU_LAT cycles in EXEC.
    localparam logic [LAT_W-1:0] c_LAT_LOAD = LAT_W'(FPU_LAT - 1);

    arb_state_e          r_state;
    logic [ID_W-1:0]     r_ptr;
    logic [LAT_W-1:0]    r_cnt;
    logic [OP_W-1:0]     r_op;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic [DATA_W-1:0]   r_rsp_data;
    logic [ID_W-1:0]     r_grant_id;

    logic [N-1:0]        w_gnt;
    logic [ID_W-1:0]     w_gnt_id;
    logic [N-1:0]        w_grant_oh;
    logic                w_idle;
    logic                w_accept;
    logic                w_rsp_hs;
    logic [OP_W-1:0]     w_sel_op;
    logic [DATA_W-1:0]   w_sel_a;
    logic [DATA_W-1:0]   w_sel_b;

    rr_picker #(
        .N      (N)
    ) u_picker (
        .req    (req_vld),
        .ptr    (r_ptr),
        .gnt    (w_gnt),
        .gnt_id (w_gnt_id)
    );

    // One-hot view of the latched grant, used to route the response and to
    // select that requester's rsp_rdy without indexing by a wider value.
    for (genvar j = 0; j < N; j++) begin : g_grant_oh
        assign w_grant_oh[j] = (r_grant_id == ID_W'(j));
    end

    // Operand slice of the picked requester
    always_comb begin
        w_sel_op = '0;
        w_sel_a  = '0;
        w_sel_b  = '0;
        for (int j = 0; j < N; j++) begin
            if (w_gnt[j]) begin
                w_sel_op = req_op[OP_W*j +: OP_W];
                w_sel_a  = req_a[DATA_W*j +: DATA_W];
                w_sel_b  = req_b[DATA_W*j +: DATA_W];
            end
        end
    end

    assign w_idle   = (r_state == IDLE);
    // The picker only grants a requester whose valid is high, so any grant
    // in IDLE is a completed request handshake.
    assign w_accept = w_idle && (|w_gnt);
    // Only the granted requester's rsp_rdy counts
    assign w_rsp_hs = |(rsp_rdy & w_grant_oh);

    assign req_rdy  = w_idle ? w_gnt : '0;
    assign rsp_vld  = (r_state == RESP) ? w_grant_oh : '0;
    assign rsp_data = r_rsp_data;
    assign fpu_op   = r_op;
    assign fpu_a    = r_a;
    assign fpu_b    = r_b;
    assign busy     = (r_state == EXEC) || (r_state == RESP);
    assign grant_id = r_grant_id;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_cnt      <= '0;
            r_op       <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_rsp_data <= '0;
            r_grant_id <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op       <= w_sel_op;
                        r_a        <= w_sel_a;
                        r_b        <= w_sel_b;
                        r_grant_id <= w_gnt_id;
                        r_ptr      <= next_ptr(w_gnt_id, N);
                        r_cnt      <= c_LAT_LOAD;
                        r_state    <= EXEC;
                    end
                end
                EXEC: begin
                    // Operands have been stable for FPU_LAT cycles when the
                    // counter reaches zero; sample the result at that edge.
                    if (r_cnt == '0) begin
                        r_rsp_data <= fpu_out;
                        r_state    <= RESP;
                    end else begin
                        r_cnt <= r_cnt - LAT_W'(1);
                    end
                end
                RESP: begin
                    if (w_rsp_hs) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
